// File: rtl/toy_pack.sv
// Shared sizing defaults and types for the rename map / checkpoint slice.
package toy_pack;

   localparam int INST_DECODE_NUM  = 4;
   localparam int ARCH_ENTRY_NUM   = 32;
   localparam int PHY_REG_ID_WIDTH = 7;
   localparam int CKPT_ENTRY_NUM   = 4;
   localparam int CKPT_ID_WIDTH    = $clog2(CKPT_ENTRY_NUM);

   typedef enum logic {
      RN_MODE_INT = 1'b0,
      RN_MODE_FP  = 1'b1
   } rn_mode_e;

   typedef logic [CKPT_ID_WIDTH-1:0] ckpt_id_t;

endpackage

// File: rtl/toy_rename_bypass.sv
// Per-lane source rename: the youngest older lane writing the same index wins, else the map value.
// Purely combinational; a lane never sees its own destination.
module toy_rename_bypass
   import toy_pack::*;
#(
   parameter int LANE_NUM   = INST_DECODE_NUM,
   parameter int AW         = $clog2(ARCH_ENTRY_NUM),
   parameter int PHY_W      = PHY_REG_ID_WIDTH,
   parameter bit ZERO_FIXED = 1'b1
) (
   input  logic [LANE_NUM-1:0]       wr_en,
   input  logic [LANE_NUM*AW-1:0]    wr_idx,
   input  logic [LANE_NUM*PHY_W-1:0] wr_phy,
   input  logic [LANE_NUM*AW-1:0]    src_idx,
   input  logic [LANE_NUM*PHY_W-1:0] map_phy,
   output logic [LANE_NUM*PHY_W-1:0] src_phy
);

   always_comb begin
      src_phy = '0;
      for (int k = 0; k < LANE_NUM; k++) begin
         src_phy[k*PHY_W +: PHY_W] = map_phy[k*PHY_W +: PHY_W];
         for (int j = 0; j < k; j++) begin
            if (wr_en[j] && (wr_idx[j*AW +: AW] == src_idx[k*AW +: AW])) begin
               src_phy[k*PHY_W +: PHY_W] = wr_phy[j*PHY_W +: PHY_W];
            end
         end
         // Integer x0 is hard-wired regardless of map contents or bypass.
         if (ZERO_FIXED && (src_idx[k*AW +: AW] == '0)) begin
            src_phy[k*PHY_W +: PHY_W] = '0;
         end
      end
   end

endmodule

// File: rtl/toy_rename_map_ckpt.sv
// Register alias table with intra-group bypass, in-order branch snapshots and two-step flush restore.
// Lookup is combinational; rn_ready drops during flush/redirect or when a snapshot is needed but none is free.
module toy_rename_map_ckpt
   import toy_pack::*;
#(
   parameter int LANE_NUM = INST_DECODE_NUM,
   parameter int ARCH_NUM = ARCH_ENTRY_NUM,
   parameter int PHY_W    = PHY_REG_ID_WIDTH,
   parameter int CKPT_NUM = CKPT_ENTRY_NUM,
   parameter int MODE     = 0,
   localparam int AW      = $clog2(ARCH_NUM),
   localparam int CW      = $clog2(CKPT_NUM)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rn_valid,
   output logic                      rn_ready,
   input  logic [LANE_NUM-1:0]       rd_en,
   input  logic [LANE_NUM*AW-1:0]    rd_idx,
   input  logic [LANE_NUM*PHY_W-1:0] rd_new_phy,
   input  logic [LANE_NUM*AW-1:0]    rs1_idx,
   input  logic [LANE_NUM*AW-1:0]    rs2_idx,
   input  logic [LANE_NUM*AW-1:0]    rs3_idx,
   output logic [LANE_NUM*PHY_W-1:0] rs1_phy,
   output logic [LANE_NUM*PHY_W-1:0] rs2_phy,
   output logic [LANE_NUM*PHY_W-1:0] rs3_phy,
   output logic [LANE_NUM*PHY_W-1:0] rd_old_phy,
   input  logic [LANE_NUM-1:0]       ckpt_req,
   output logic [CW-1:0]             ckpt_id,
   output logic                      ckpt_full,
   input  logic                      ckpt_free_en,
   input  logic                      redirect_en,
   input  logic [CW-1:0]             redirect_ckpt_id,
   input  logic                      flush_en,
   input  logic [ARCH_NUM*PHY_W-1:0] flush_map
);

   localparam bit          ARCH0_FIXED   = (MODE == int'(RN_MODE_INT));
   localparam logic [CW:0] CKPT_FULL_CNT = (CW+1)'(CKPT_NUM);

   logic [PHY_W-1:0]          map_q    [ARCH_NUM];
   logic [PHY_W-1:0]          map_nxt  [ARCH_NUM];
   logic [PHY_W-1:0]          snap_map [ARCH_NUM];
   logic [PHY_W-1:0]          ckpt_q   [CKPT_NUM][ARCH_NUM];
   logic [ARCH_NUM*PHY_W-1:0] stage_q;
   logic                      flush_pend;
   logic [CW-1:0]             head_q;
   logic [CW-1:0]             tail_q;
   logic [CW-1:0]             head_inc;
   logic [CW-1:0]             rdr_ofs;
   logic [CW:0]               count_q;

   logic [LANE_NUM-1:0]       wr_en;
   logic [LANE_NUM*PHY_W-1:0] rs1_map;
   logic [LANE_NUM*PHY_W-1:0] rs2_map;
   logic [LANE_NUM*PHY_W-1:0] rs3_map;
   logic [LANE_NUM*PHY_W-1:0] rd_map;
   logic                      ckpt_any;
   logic                      rn_fire;
   logic                      ckpt_alloc;
   logic                      ckpt_free;

   assign ckpt_any   = |ckpt_req;
   assign ckpt_full  = (count_q == CKPT_FULL_CNT);
   assign ckpt_id    = tail_q;
   assign rn_ready   = !flush_en && !flush_pend && !redirect_en && !(ckpt_any && ckpt_full);
   assign rn_fire    = rn_valid && rn_ready;
   assign ckpt_alloc = rn_fire && ckpt_any;
   assign ckpt_free  = ckpt_free_en && (count_q != '0);
   assign head_inc   = head_q + CW'(ckpt_free);
   assign rdr_ofs    = redirect_ckpt_id - head_q;

   always_comb begin
      wr_en   = '0;
      rs1_map = '0;
      rs2_map = '0;
      rs3_map = '0;
      rd_map  = '0;
      for (int k = 0; k < LANE_NUM; k++) begin
         wr_en[k] = rd_en[k] && !(ARCH0_FIXED && (rd_idx[k*AW +: AW] == '0));
         rs1_map[k*PHY_W +: PHY_W] = map_q[rs1_idx[k*AW +: AW]];
         rs2_map[k*PHY_W +: PHY_W] = map_q[rs2_idx[k*AW +: AW]];
         rs3_map[k*PHY_W +: PHY_W] = map_q[rs3_idx[k*AW +: AW]];
         rd_map[k*PHY_W +: PHY_W]  = map_q[rd_idx[k*AW +: AW]];
      end
   end

   // Lanes apply in order so the highest lane wins; the snapshot freezes right after the branch lane.
   always_comb begin
      map_nxt  = map_q;
      snap_map = map_q;
      for (int k = 0; k < LANE_NUM; k++) begin
         if (wr_en[k]) begin
            map_nxt[rd_idx[k*AW +: AW]] = rd_new_phy[k*PHY_W +: PHY_W];
         end
         if (ckpt_req[k]) begin
            snap_map = map_nxt;
         end
      end
   end

   toy_rename_bypass #(.LANE_NUM(LANE_NUM), .AW(AW), .PHY_W(PHY_W), .ZERO_FIXED(ARCH0_FIXED)) u_byp_rs1 (
      .wr_en(wr_en), .wr_idx(rd_idx), .wr_phy(rd_new_phy),
      .src_idx(rs1_idx), .map_phy(rs1_map), .src_phy(rs1_phy)
   );

   toy_rename_bypass #(.LANE_NUM(LANE_NUM), .AW(AW), .PHY_W(PHY_W), .ZERO_FIXED(ARCH0_FIXED)) u_byp_rs2 (
      .wr_en(wr_en), .wr_idx(rd_idx), .wr_phy(rd_new_phy),
      .src_idx(rs2_idx), .map_phy(rs2_map), .src_phy(rs2_phy)
   );

   toy_rename_bypass #(.LANE_NUM(LANE_NUM), .AW(AW), .PHY_W(PHY_W), .ZERO_FIXED(ARCH0_FIXED)) u_byp_rs3 (
      .wr_en(wr_en), .wr_idx(rd_idx), .wr_phy(rd_new_phy),
      .src_idx(rs3_idx), .map_phy(rs3_map), .src_phy(rs3_phy)
   );

   toy_rename_bypass #(.LANE_NUM(LANE_NUM), .AW(AW), .PHY_W(PHY_W), .ZERO_FIXED(ARCH0_FIXED)) u_byp_rd (
      .wr_en(wr_en), .wr_idx(rd_idx), .wr_phy(rd_new_phy),
      .src_idx(rd_idx), .map_phy(rd_map), .src_phy(rd_old_phy)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ARCH_NUM; i++) begin
            map_q[i] <= PHY_W'(i);
         end
         stage_q    <= '0;
         flush_pend <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         flush_pend <= flush_en;
         if (flush_en) begin
            stage_q <= flush_map;
         end
         if (flush_pend) begin
            for (int i = 0; i < ARCH_NUM; i++) begin
               map_q[i] <= stage_q[i*PHY_W +: PHY_W];
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end else if (!flush_en) begin
            if (redirect_en) begin
               // A same-cycle free retires the head first, so the live count is measured from it.
               map_q   <= ckpt_q[redirect_ckpt_id];
               head_q  <= head_inc;
               tail_q  <= redirect_ckpt_id;
               count_q <= {1'b0, redirect_ckpt_id - head_inc};
            end else begin
               if (rn_fire) begin
                  map_q <= map_nxt;
               end
               if (ckpt_alloc) begin
                  tail_q <= tail_q + CW'(1);
               end
               head_q  <= head_inc;
               count_q <= count_q + (CW+1)'(ckpt_alloc) - (CW+1)'(ckpt_free);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (ckpt_alloc) begin
         ckpt_q[tail_q] <= snap_map;
      end
   end

   a_free_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
      !(ckpt_free_en && (count_q == '0)));

   a_redirect_live: assert property (@(posedge clk) disable iff (!rst_n)
      (redirect_en && !flush_en && !flush_pend) |-> ({1'b0, rdr_ofs} < count_q));

endmodule

// File: tb/tb_toy_rename_map_ckpt.sv
// Directed bench: the driver queues hand-computed expectations, a negedge monitor drains and compares.
module tb_toy_rename_map_ckpt;
   import toy_pack::*;

   localparam int LN = 4;
   localparam int AN = 32;
   localparam int PW = 7;
   localparam int CN = 4;
   localparam int AW = 5;
   localparam int CW = 2;

   localparam int S_RS1 = 0, S_RS2 = 1, S_RS3 = 2, S_OLD = 3, S_ID = 4, S_FULL = 5, S_RDY = 6;
   localparam int S_FRS1 = 7, S_FRS2 = 8, S_FOLD = 9;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            rn_valid;
   logic            rn_ready, fp_ready;
   logic [LN-1:0]   rd_en, ckpt_req;
   logic [LN*AW-1:0] rd_idx, rs1_idx, rs2_idx, rs3_idx;
   logic [LN*PW-1:0] rd_new_phy;
   logic [LN*PW-1:0] rs1_phy, rs2_phy, rs3_phy, rd_old_phy;
   logic [LN*PW-1:0] fp_rs1, fp_rs2, fp_rs3, fp_old;
   logic [CW-1:0]   ckpt_id, fp_ckpt_id, redirect_ckpt_id;
   logic            ckpt_full, fp_full;
   logic            ckpt_free_en, redirect_en, flush_en;
   logic [AN*PW-1:0] flush_map;

   typedef struct {
      string nm;
      int    sel;
      int    lane;
      int    val;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        cur;
   logic [31:0] act;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   toy_rename_map_ckpt #(.LANE_NUM(LN), .ARCH_NUM(AN), .PHY_W(PW), .CKPT_NUM(CN), .MODE(0)) dut (
      .clk(clk), .rst_n(rst_n), .rn_valid(rn_valid), .rn_ready(rn_ready),
      .rd_en(rd_en), .rd_idx(rd_idx), .rd_new_phy(rd_new_phy),
      .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs3_idx(rs3_idx),
      .rs1_phy(rs1_phy), .rs2_phy(rs2_phy), .rs3_phy(rs3_phy), .rd_old_phy(rd_old_phy),
      .ckpt_req(ckpt_req), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full), .ckpt_free_en(ckpt_free_en),
      .redirect_en(redirect_en), .redirect_ckpt_id(redirect_ckpt_id),
      .flush_en(flush_en), .flush_map(flush_map)
   );

   toy_rename_map_ckpt #(.LANE_NUM(LN), .ARCH_NUM(AN), .PHY_W(PW), .CKPT_NUM(CN), .MODE(1)) dut_fp (
      .clk(clk), .rst_n(rst_n), .rn_valid(rn_valid), .rn_ready(fp_ready),
      .rd_en(rd_en), .rd_idx(rd_idx), .rd_new_phy(rd_new_phy),
      .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs3_idx(rs3_idx),
      .rs1_phy(fp_rs1), .rs2_phy(fp_rs2), .rs3_phy(fp_rs3), .rd_old_phy(fp_old),
      .ckpt_req(ckpt_req), .ckpt_id(fp_ckpt_id), .ckpt_full(fp_full), .ckpt_free_en(ckpt_free_en),
      .redirect_en(redirect_en), .redirect_ckpt_id(redirect_ckpt_id),
      .flush_en(flush_en), .flush_map(flush_map)
   );

   function automatic logic [31:0] observe(int sel, int lane);
      case (sel)
         S_RS1:   return 32'(rs1_phy[lane*PW +: PW]);
         S_RS2:   return 32'(rs2_phy[lane*PW +: PW]);
         S_RS3:   return 32'(rs3_phy[lane*PW +: PW]);
         S_OLD:   return 32'(rd_old_phy[lane*PW +: PW]);
         S_ID:    return 32'(ckpt_id);
         S_FULL:  return 32'(ckpt_full);
         S_RDY:   return 32'(rn_ready);
         S_FRS1:  return 32'(fp_rs1[lane*PW +: PW]);
         S_FRS2:  return 32'(fp_rs2[lane*PW +: PW]);
         S_FOLD:  return 32'(fp_old[lane*PW +: PW]);
         default: return 32'hdead_beef;
      endcase
   endfunction

   always @(negedge clk) begin
      while (exp_q.size() != 0) begin
         cur = exp_q.pop_front();
         act = observe(cur.sel, cur.lane);
         checks++;
         if (act !== 32'(cur.val)) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", cur.nm, act, cur.val);
         end
      end
   end

   task automatic clr();
      rn_valid         = 1'b0;
      rd_en            = '0;
      ckpt_req         = '0;
      rd_idx           = '0;
      rd_new_phy       = '0;
      rs1_idx          = '0;
      rs2_idx          = '0;
      rs3_idx          = '0;
      ckpt_free_en     = 1'b0;
      redirect_en      = 1'b0;
      redirect_ckpt_id = '0;
      flush_en         = 1'b0;
   endtask

   task automatic wr(int k, int rd, int nphy);
      rd_en[k]              = 1'b1;
      rd_idx[k*AW +: AW]    = AW'(rd);
      rd_new_phy[k*PW +: PW] = PW'(nphy);
   endtask

   task automatic src(int k, int s1, int s2, int s3);
      rs1_idx[k*AW +: AW] = AW'(s1);
      rs2_idx[k*AW +: AW] = AW'(s2);
      rs3_idx[k*AW +: AW] = AW'(s3);
   endtask

   task automatic ex(string nm, int sel, int lane, int val);
      exp_t e;
      e.nm = nm; e.sel = sel; e.lane = lane; e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
      clr();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < AN; i++) flush_map[i*PW +: PW] = PW'(i + 64);
      clr();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset state
      src(0, 9, 0, 0);
      ex("rst_ready", S_RDY, 0, 1);
      ex("rst_full", S_FULL, 0, 0);
      ex("rst_id", S_ID, 0, 0);
      ex("rst_map9", S_RS1, 0, 9);
      ex("rst_int0", S_RS2, 0, 0);
      ex("rst_fp0", S_FRS2, 0, 0);
      nxt();

      // RAW bypass
      rn_valid = 1'b1; wr(0, 5, 40); src(0, 5, 0, 0); src(1, 5, 0, 0); src(2, 5, 0, 0);
      ex("raw_rs1_l0", S_RS1, 0, 5);
      ex("raw_old_l0", S_OLD, 0, 5);
      ex("raw_rs1_l1", S_RS1, 1, 40);
      ex("raw_rs1_l2", S_RS1, 2, 40);
      nxt();
      src(0, 5, 0, 0);
      ex("raw_map5", S_RS1, 0, 40);
      nxt();

      // WAW within a group
      rn_valid = 1'b1; wr(0, 3, 33); wr(2, 3, 35); src(1, 0, 3, 0); src(3, 0, 3, 0);
      ex("waw_rs2_l3", S_RS2, 3, 35);
      ex("waw_rs2_l1", S_RS2, 1, 33);
      ex("waw_old_l2", S_OLD, 2, 33);
      ex("waw_old_l0", S_OLD, 0, 3);
      nxt();
      src(0, 3, 0, 0);
      ex("waw_map3", S_RS1, 0, 35);
      nxt();

      // Snapshot after lane 1 excludes lane 2
      rn_valid = 1'b1; wr(0, 7, 50); ckpt_req[1] = 1'b1; wr(2, 8, 51); src(3, 8, 0, 7);
      ex("ck_id", S_ID, 0, 0);
      ex("ck_ready", S_RDY, 0, 1);
      ex("ck_rs1_l3", S_RS1, 3, 51);
      ex("ck_rs3_l3", S_RS3, 3, 50);
      nxt();
      rn_valid = 1'b1; wr(0, 7, 60); src(0, 0, 0, 8);
      ex("ck_map8", S_RS3, 0, 51);
      ex("ck_tail1", S_ID, 0, 1);
      nxt();
      redirect_en = 1'b1; redirect_ckpt_id = 2'd0; rn_valid = 1'b1; wr(0, 9, 99);
      ex("rdr_ready", S_RDY, 0, 0);
      nxt();
      src(0, 7, 8, 9); src(1, 5, 0, 0);
      ex("rdr_map7", S_RS1, 0, 50);
      ex("rdr_map8", S_RS2, 0, 8);
      ex("rdr_map9", S_RS3, 0, 9);
      ex("rdr_map5", S_RS1, 1, 40);
      ex("rdr_tail", S_ID, 0, 0);
      ex("rdr_full", S_FULL, 0, 0);
      nxt();

      // Fill all four slots
      for (int k = 0; k < 4; k++) begin
         rn_valid = 1'b1; wr(0, 11, 80 + k); ckpt_req[1] = 1'b1; wr(2, 11, 90 + k); src(3, 11, 0, 0);
         ex($sformatf("fill%0d_id", k), S_ID, 0, k);
         ex($sformatf("fill%0d_ready", k), S_RDY, 0, 1);
         ex($sformatf("fill%0d_full", k), S_FULL, 0, 0);
         ex($sformatf("fill%0d_rs1_l3", k), S_RS1, 3, 90 + k);
         ex($sformatf("fill%0d_old_l2", k), S_OLD, 2, 80 + k);
         ex($sformatf("fill%0d_old_l0", k), S_OLD, 0, (k == 0) ? 11 : 89 + k);
         nxt();
      end
      rn_valid = 1'b1; ckpt_req[1] = 1'b1; wr(0, 12, 77);
      ex("full_flag", S_FULL, 0, 1);
      ex("full_stall", S_RDY, 0, 0);
      nxt();
      rn_valid = 1'b1; wr(0, 10, 70);
      ex("full_nockpt_ready", S_RDY, 0, 1);
      nxt();
      rn_valid = 1'b1; ckpt_req[1] = 1'b1; wr(0, 12, 78); ckpt_free_en = 1'b1; src(0, 0, 12, 0); src(3, 10, 0, 0);
      ex("free_stall", S_RDY, 0, 0);
      ex("free_map12", S_RS2, 0, 12);
      ex("free_map10", S_RS1, 3, 70);
      nxt();
      rn_valid = 1'b1; ckpt_req[0] = 1'b1; wr(0, 12, 101); wr(1, 11, 100); src(0, 12, 0, 0);
      ex("free_full", S_FULL, 0, 0);
      ex("free_ready", S_RDY, 0, 1);
      ex("free_wrap_id", S_ID, 0, 0);
      ex("free_map12b", S_RS1, 0, 12);
      nxt();

      // Redirect to slot 3 with a simultaneous free of the head
      redirect_en = 1'b1; redirect_ckpt_id = 2'd3; ckpt_free_en = 1'b1; src(0, 11, 0, 0);
      ex("rdr2_full", S_FULL, 0, 1);
      ex("rdr2_ready", S_RDY, 0, 0);
      ex("rdr2_pre11", S_RS1, 0, 100);
      nxt();
      src(0, 11, 10, 12);
      ex("rdr2_map11", S_RS1, 0, 83);
      ex("rdr2_map10", S_RS2, 0, 10);
      ex("rdr2_map12", S_RS3, 0, 12);
      ex("rdr2_tail", S_ID, 0, 3);
      ex("rdr2_notfull", S_FULL, 0, 0);
      nxt();
      for (int k = 0; k < 3; k++) begin
         rn_valid = 1'b1; ckpt_req[0] = 1'b1;
         ex($sformatf("refill%0d_id", k), S_ID, 0, (k + 3) % 4);
         ex($sformatf("refill%0d_full", k), S_FULL, 0, 0);
         ex($sformatf("refill%0d_ready", k), S_RDY, 0, 1);
         nxt();
      end
      rn_valid = 1'b1; ckpt_req[0] = 1'b1;
      ex("refill_full", S_FULL, 0, 1);
      ex("refill_stall", S_RDY, 0, 0);
      nxt();

      // Flush with a coincident redirect and rename group
      flush_en = 1'b1; redirect_en = 1'b1; redirect_ckpt_id = 2'd0; rn_valid = 1'b1; wr(0, 9, 5);
      ex("fl0_ready", S_RDY, 0, 0);
      nxt();
      src(0, 9, 0, 0);
      ex("fl1_ready", S_RDY, 0, 0);
      ex("fl1_map9", S_RS1, 0, 9);
      ex("fl1_full", S_FULL, 0, 1);
      nxt();
      src(0, 9, 0, 0);
      ex("fl2_ready", S_RDY, 0, 1);
      ex("fl2_map9", S_RS1, 0, 73);
      ex("fl2_int0", S_RS2, 0, 0);
      ex("fl2_fp0", S_FRS2, 0, 64);
      ex("fl2_full", S_FULL, 0, 0);
      ex("fl2_id", S_ID, 0, 0);
      nxt();

      // Arch 0 handling: INT ignores, FP renames
      rn_valid = 1'b1; wr(0, 0, 90); src(1, 0, 0, 0);
      ex("m_int_rs1_l1", S_RS1, 1, 0);
      ex("m_fp_rs1_l1", S_FRS1, 1, 90);
      ex("m_int_old_l0", S_OLD, 0, 0);
      ex("m_fp_old_l0", S_FOLD, 0, 64);
      nxt();
      src(0, 0, 0, 0); src(1, 13, 0, 0);
      ex("m_int_map0", S_RS1, 0, 0);
      ex("m_fp_map0", S_FRS1, 0, 90);
      ex("m_map13", S_RS1, 1, 77);
      nxt();

      // Asynchronous reset in mid-cycle
      rst_n = 1'b0; src(0, 13, 0, 0); src(1, 0, 0, 0);
      ex("arst_map13", S_RS1, 0, 13);
      ex("arst_fp0", S_FRS1, 1, 0);
      ex("arst_full", S_FULL, 0, 0);
      ex("arst_ready", S_RDY, 0, 1);
      nxt();
      rst_n = 1'b1;

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: pending=%0d want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/toy_rename_map_ckpt.md
Name: toy_rename_map_ckpt

Overview:
- Parametrised register alias table (RAT) for the dispatch stage. Maps architectural to physical register ids for a rename group of LANE_NUM instructions.
- Resolves intra-group RAW/WAW dependences by bypass and returns each destination's previous mapping so it can be released at commit.
- Keeps CKPT_NUM in-order branch snapshots for single-cycle mispredict recovery. Also supports a full flush restore from the committed map.
- Sits between decode/physical-id allocation and the issue queues; one instance each for INT and FP.

Parameters:
- LANE_NUM, 4, instructions renamed per group.
- ARCH_NUM, 32, architectural registers; index width AW = $clog2(ARCH_NUM).
- PHY_W, 7, physical register id width.
- CKPT_NUM, 4, snapshot slots; power of two; id width CW = $clog2(CKPT_NUM).
- MODE, 0, 0 = INT (arch 0 hard-mapped to phy 0, never renamed, never bypassed); 1 = FP (arch 0 renamable).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rn_valid  in  1  rename group valid
- rn_ready  out  1  group accepted this cycle
- rd_en  in  LANE_NUM  lane writes a destination
- rd_idx  in  AW x LANE_NUM  destination arch index
- rd_new_phy  in  PHY_W x LANE_NUM  newly allocated phy id
- rs1_idx, rs2_idx, rs3_idx  in  AW x LANE_NUM  source arch indices
- rs1_phy, rs2_phy, rs3_phy  out  PHY_W x LANE_NUM  renamed sources
- rd_old_phy  out  PHY_W x LANE_NUM  prior mapping of rd_idx, for release
- ckpt_req  in  LANE_NUM  lane is a branch needing a snapshot; at most one bit set
- ckpt_id  out  CW  slot assigned to the requesting lane
- ckpt_full  out  1  all slots in use
- ckpt_free_en  in  1  oldest branch resolved correctly; release head slot
- redirect_en  in  1  mispredict recovery
- redirect_ckpt_id  in  CW  slot to restore
- flush_en  in  1  full pipeline flush
- flush_map  in  PHY_W x ARCH_NUM  committed map to restore

Behaviour:
- Reset:
  - map[i] = i for every i.
  - Checkpoint head = tail = count = 0; ckpt_full = 0; flush_pend = 0.
  - rn_ready = 1 after reset.
- Lookup is combinational off the current map plus bypass:
  - rsN_phy[k] = rd_new_phy[j] for the highest j < k with rd_en[j] and rd_idx[j] == rsN_idx[k]; otherwise map[rsN_idx[k]].
  - rd_old_phy[k] uses the same rule with rd_idx[k].
  - A lane's own rd is never visible to that lane's sources.
- MODE 0, arch index 0:
  - Lookup always returns 0.
  - rd_en with rd_idx == 0 is ignored for map update and bypass.
- Update: on the clock edge where rn_valid && rn_ready, the map takes the writes of all rd_en lanes. On duplicate rd_idx within a group, the highest lane wins.
- Checkpoint allocation:
  - Happens when the accepted group has ckpt_req[k] set.
  - Slot[tail] captures the map after applying lanes 0..k only; later lanes are excluded.
  - ckpt_id = tail, combinationally. Then tail++ (mod CKPT_NUM) and count++.
- ckpt_free_en: head++ and count--.
  - Free and allocate in the same cycle: count is unchanged.
  - Free while count == 0 is ignored and flagged by an assertion.
- ckpt_full = (count == CKPT_NUM).
- rn_ready = !flush_en && !flush_pend && !redirect_en && !(|ckpt_req && ckpt_full). When rn_ready is low, no map or checkpoint state changes from the rename path.
- Redirect, on the edge where redirect_en is sampled:
  - map <= slot[redirect_ckpt_id].
  - tail <= redirect_ckpt_id. This frees that slot and all younger ones.
  - count <= (redirect_ckpt_id - head) mod CKPT_NUM.
  - A same-cycle ckpt_free_en is applied first: head++ before the count computation.
  - redirect_ckpt_id must be within [head, tail) (assertion).
- Flush, two-step restore:
  - flush_en sets flush_pend at the edge and captures flush_map into a staging register.
  - In the next cycle the map is loaded from staging; head = tail = count = 0; flush_pend clears.
  - rn_ready stays low for both cycles. Flush restore takes one cycle of latency after flush_en.
- Priority: flush_en / flush_pend > redirect_en > rename update. A redirect coincident with a flush is dropped.
- Asynchronous reset mid-operation returns all state to the reset values immediately.

Decomposition:
- The INT/FP mode enum and the checkpoint id typedef go in toy_pack. LANE_NUM/ARCH_NUM/PHY_W default constants also go there: INST_DECODE_NUM, ARCH_ENTRY_NUM, PHY_REG_ID_WIDTH.
- One sub-module: toy_rename_bypass. It is purely combinational: per-lane priority match of a source index against older lanes. It is instanced for rs1, rs2, rs3 and rd_old.
- Map storage, checkpoint FIFO and flush staging stay in the top module.

Test Plan:
- Reset, then group lane0 rs1 = 5, rd = 5 → new phy 40; lane1 rs1 = 5 → rs1_phy[0] = 5, rd_old_phy[0] = 5, rs1_phy[1] = 40. Next cycle, lookup of 5 returns 40.
- WAW: lanes 0 and 2 both rd = 3 with new phy 33 and 35; lane3 rs2 = 3 → rs2_phy[3] = 35, rd_old_phy[2] = 33, map[3] = 35 after the edge.
- Checkpoint:
  - lane1 ckpt_req; lane0 rd = 7 → 50, lane2 rd = 8 → 51 → ckpt_id = 0.
  - Redirect to 0 later: map[7] = 50, map[8] = 8, count = 0.
- Fill: 4 groups each with a ckpt_req → ckpt_full = 1. A fifth group with ckpt_req gives rn_ready = 0; a group without ckpt_req is accepted. A simultaneous ckpt_free_en gives count = 3 and the next request is accepted.
- Flush with flush_map[i] = i + 64 → rn_ready low for 2 cycles; then lookup of 9 returns 73 and ckpt_full = 0. A redirect in the flush cycle is ignored.
- MODE = 0, rd = 0 with new phy 90, lane1 rs1 = 0 → rs1_phy[1] = 0 and map[0] stays 0. With MODE = 1 the same stimulus gives 90.
